multicycle_maindec: RTL
=======================

MULTICYCLE_MAINDEC -- requirements
Module: multicycle_maindec

Interface
REQ-001 Parameter: OP_W, 11, opcode width; Op bits below the upper 11 SHALL be ignored when OP_W > 11.
REQ-002 Parameter: MEM_TIMEOUT, 16, max consecutive cycles with mem_ready low in a memory state before fault; range 1..255.
REQ-003 Parameter: CNT_W, 8, width of retired-instruction counter.
REQ-004 Port: clk  in  1  clock, all state on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: Op  in  OP_W  opcode field of instruction register; upper 11 bits are decoded.
REQ-007 Port: mem_ready  in  1  memory handshake completion, sampled on rising edge.
REQ-008 Port: Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
REQ-009 Port: ALUOp  out  2  ALU control class: 00 add, 01 pass-B/zero test, 10 R-type funct.
REQ-010 Port: IRWrite, PCWrite, mem_req  out  1 each  IR load, PC+4 update, memory request.
REQ-011 Port: instr_done  out  1  one-cycle pulse when an instruction retires.
REQ-012 Port: retired  out  CNT_W  count of retired instructions.
REQ-013 Port: fault  out  1  sticky illegal-opcode or memory-timeout indication.
REQ-014 Port: state  out  4  current state encoding, for debug.

Function
REQ-015 Controller SHALL be a Moore FSM; all outputs except retired/fault SHALL be decoded from current state only.
REQ-016 States and encodings: FETCH 0, DECODE 1, EXEC_R 2, WB_R 3, ADDR 4, MEM_LD 5, WB_LD 6, MEM_ST 7, BRANCH 8, FAULT 9; unused codes SHALL go to FAULT.
REQ-017 FETCH: MemRead=1, mem_req=1, IRWrite=1; on mem_ready=1 -> DECODE with PCWrite=1 in that same cycle; else stay.
REQ-018 DECODE (all controls 0): ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R; LDUR 11111000010 or STUR 11111000000 -> ADDR; CBZ 10110100xxx -> BRANCH; any other -> FAULT.
REQ-019 EXEC_R: Reg2Loc=0, ALUSrc=0, ALUOp=10 -> WB_R unconditionally.
REQ-020 WB_R: RegWrite=1, MemtoReg=0, instr_done=1 -> FETCH.
REQ-021 ADDR: ALUSrc=1, ALUOp=00, Reg2Loc=1 -> MEM_LD if Op = LDUR, else MEM_ST.
REQ-022 MEM_LD: MemRead=1, mem_req=1, ALUSrc=1; on mem_ready=1 -> WB_LD.
REQ-023 WB_LD: RegWrite=1, MemtoReg=1, instr_done=1 -> FETCH.
REQ-024 MEM_ST: MemWrite=1, mem_req=1, Reg2Loc=1, ALUSrc=1; on mem_ready=1 -> FETCH with instr_done=1 in that cycle.
REQ-025 BRANCH: Reg2Loc=1, ALUOp=01, Branch=1, instr_done=1 for exactly one cycle -> FETCH.
REQ-026 Cycle counts from FETCH entry, zero-wait memory: R-type 4, LDUR 5, STUR 4, CBZ 3.
REQ-027 Wait counter SHALL clear on entry to FETCH, MEM_LD and MEM_ST, increment each cycle in those states with mem_ready=0, and on reaching MEM_TIMEOUT force next state FAULT.
REQ-028 mem_ready=1 in the cycle the counter reaches MEM_TIMEOUT SHALL take precedence (normal transition, no fault).
REQ-029 mem_ready outside FETCH/MEM_LD/MEM_ST SHALL be ignored.
REQ-030 retired SHALL increment by 1 on every instr_done and wrap modulo 2^CNT_W with no saturation or flag.
REQ-031 FAULT: all datapath controls, mem_req, instr_done 0; fault=1; exit only via reset; retired frozen.

Reset
REQ-032 reset=0 at a rising edge SHALL force state FETCH, wait counter 0, retired 0, fault 0, regardless of current state, including mid-handshake.
REQ-033 During reset and the cycle after release, outputs SHALL equal FETCH decode (MemRead=1, mem_req=1, IRWrite=1, others 0).

Verification
REQ-034 Reset release, Op=ADD, mem_ready=1 always -> states 0,1,2,3,0; instr_done pulses in cycle 4; retired=1; RegWrite=1 only in WB_R.
REQ-035 Op=LDUR, mem_ready low 3 cycles in MEM_LD then high -> MEM_LD held 4 cycles, MemRead=1 throughout, WB_LD MemtoReg=1, retired increments once.
REQ-036 Op=11111111111 in DECODE -> FAULT next cycle, fault=1, all controls 0 for 20 cycles, then reset=0 one cycle -> FETCH, fault=0.
REQ-037 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 wait cycles; repeat with mem_ready=1 in 4th cycle -> DECODE, no fault.
REQ-038 CNT_W=2, five back-to-back CBZ -> retired sequence 1,2,3,0,1; each instruction 3 cycles; Branch=1 once per instruction.
REQ-039 reset=0 asserted while in MEM_ST with mem_ready=0 -> next state FETCH, MemWrite=0, retired=0, no instr_done.

Source files
------------

// File: rtl/multicycle_maindec.sv
// Multicycle main decoder: Moore controller sequencing fetch, decode, execute,
// memory and write-back for ADD/SUB/AND/ORR, LDUR, STUR and CBZ.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-low reset
//   Op                instruction opcode field; only the upper 11 bits decode
//   mem_ready         memory handshake completion
//   Reg2Loc..Branch   datapath controls, ALUOp ALU control class
//   IRWrite, PCWrite  IR load and PC+4 update
//   mem_req           memory request
//   instr_done        one-cycle pulse when an instruction retires
//   retired           retired-instruction count, wraps
//   fault             sticky illegal-opcode / memory-timeout flag
//   state             current state encoding (debug)
module multicycle_maindec #(
    parameter int unsigned OP_W        = 11,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  Op,
    input  logic             mem_ready,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             mem_req,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExecR  = 4'd2,
        StWbR    = 4'd3,
        StAddr   = 4'd4,
        StMemLd  = 4'd5,
        StWbLd   = 4'd6,
        StMemSt  = 4'd7,
        StBranch = 4'd8,
        StFault  = 4'd9
    } state_e;

    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [7:0]  OpCbz  = 8'b10110100;

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             fault_q;

    logic [10:0] op_hi;
    logic        unused_op;
    logic        mem_state;
    logic        timeout;
    state_e      out_st;
    logic        rdy_out;

    assign op_hi     = Op[OP_W-1 -: 11];
    assign unused_op = ^Op;

    assign mem_state = (state_q == StFetch) || (state_q == StMemLd) || (state_q == StMemSt);
    // Timeout fires on the cycle the count would reach the limit; a ready in
    // that same cycle wins because it is checked first below.
    assign timeout   = mem_state && !mem_ready && ((wait_q + 8'd1) == 8'(MEM_TIMEOUT));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready)    state_d = StDecode;
                else if (timeout) state_d = StFault;
            end
            StDecode: begin
                if (op_hi == OpAdd || op_hi == OpSub || op_hi == OpAnd || op_hi == OpOrr)
                    state_d = StExecR;
                else if (op_hi == OpLdur || op_hi == OpStur)
                    state_d = StAddr;
                else if (op_hi[10:3] == OpCbz)
                    state_d = StBranch;
                else
                    state_d = StFault;
            end
            StExecR:  state_d = StWbR;
            StWbR:    state_d = StFetch;
            StAddr:   state_d = (op_hi == OpLdur) ? StMemLd : StMemSt;
            StMemLd: begin
                if (mem_ready)    state_d = StWbLd;
                else if (timeout) state_d = StFault;
            end
            StWbLd:   state_d = StFetch;
            StMemSt: begin
                if (mem_ready)    state_d = StFetch;
                else if (timeout) state_d = StFault;
            end
            StBranch: state_d = StFetch;
            StFault:  state_d = StFault;
            default:  state_d = StFault;
        endcase
    end

    // Wait counter clears on any state change, so every memory state is
    // entered with a zero count.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)          wait_d = 8'd0;
        else if (mem_state && !mem_ready) wait_d = wait_q + 8'd1;
    end

    assign retired_d = instr_done ? (retired_q + CNT_W'(1)) : retired_q;

    // While reset is held the outputs show the FETCH decode with no handshake.
    assign out_st  = reset ? state_q : StFetch;
    assign rdy_out = reset & mem_ready;

    always_comb begin
        Reg2Loc    = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        ALUOp      = 2'b00;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        mem_req    = 1'b0;
        instr_done = 1'b0;
        unique case (out_st)
            StFetch: begin
                MemRead = 1'b1;
                mem_req = 1'b1;
                IRWrite = 1'b1;
                PCWrite = rdy_out;
            end
            StExecR:  ALUOp = 2'b10;
            StWbR: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StAddr: begin
                ALUSrc  = 1'b1;
                Reg2Loc = 1'b1;
            end
            StMemLd: begin
                MemRead = 1'b1;
                mem_req = 1'b1;
                ALUSrc  = 1'b1;
            end
            StWbLd: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            StMemSt: begin
                MemWrite   = 1'b1;
                mem_req    = 1'b1;
                Reg2Loc    = 1'b1;
                ALUSrc     = 1'b1;
                instr_done = rdy_out;
            end
            StBranch: begin
                Reg2Loc    = 1'b1;
                ALUOp      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StFetch;
            wait_q    <= 8'd0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            fault_q   <= fault_q | (state_d == StFault);
        end
    end

    assign retired = retired_q;
    assign fault   = fault_q;
    assign state   = state_q;

endmodule
